conv_seq_ctrl: RTL

Parametrised second-generation sequencer for the convolution accelerator. It takes a run configuration, then drives beat-wise loading of the input and kernel memories. It sequences the multiply-accumulate datapath for every output sample, writes the results to output memory, and streams them back to the host. All counters and addresses are generated internally; the datapath and memories sit outside this block.

---
 rtl/conv_pkg.sv | 20 ++
 rtl/conv_addr_gen.sv | 120 ++++++++++++
 rtl/conv_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution sequencer.
// The optional stride feature is enabled with the CONV_STRIDE_EN macro.
package conv_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int KLEN_W_DEF = 6;
    localparam int BEAT_DEF   = 4;
    localparam int STRIDE_W   = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CFG     = 3'd1,
        LOAD_IN = 3'd2,
        LOAD_KR = 3'd3,
        CONV    = 3'd4,
        WR_OUT  = 3'd5,
        RD_OUT  = 3'd6
    } state_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Load, tap, output and read-back counters plus memory address generation.
// Stride (CONV_STRIDE_EN) enters only as the per-output base increment.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int KLEN_W = KLEN_W_DEF,
    parameter int BEAT   = BEAT_DEF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  state_t              state_i,
    input  logic                abort_i,
    input  logic                ld_valid_i,
    input  logic                rd_ready_i,
    input  logic [ADDR_W-1:0]   n_i,
    input  logic [KLEN_W-1:0]   k_i,
    input  logic [ADDR_W-1:0]   m_i,
    input  logic [STRIDE_W-1:0] stride_i,
    output logic [ADDR_W-1:0]   in_addr_o,
    output logic [KLEN_W-1:0]   kr_addr_o,
    output logic [ADDR_W-1:0]   out_addr_o,
    output logic                ld_last_o,
    output logic                tap_last_o,
    output logic                out_last_o,
    output logic                rd_last_o
);

    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [ADDR_W-1:0] o_q, o_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [KLEN_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] ld_limit;
    logic [ADDR_W:0]   ld_next;

    // One extra bit so the final beat's address step cannot wrap past the limit.
    assign ld_limit   = (state_i == LOAD_KR) ? ADDR_W'(k_i) : n_i;
    assign ld_next    = {1'b0, ld_addr_q} + (ADDR_W+1)'(BEAT);
    assign ld_last_o  = (ld_next >= {1'b0, ld_limit});
    assign tap_last_o = (k_q == k_i - KLEN_W'(1));
    assign out_last_o = (o_q == m_i - ADDR_W'(1));
    assign rd_last_o  = (rd_q == m_i - ADDR_W'(1));

    always_comb begin
        ld_addr_d = ld_addr_q;
        k_d       = k_q;
        o_d       = o_q;
        base_d    = base_q;
        rd_d      = rd_q;
        if (abort_i) begin
            ld_addr_d = '0;
            k_d       = '0;
            o_d       = '0;
            base_d    = '0;
            rd_d      = '0;
        end else begin
            case (state_i)
                LOAD_IN, LOAD_KR: begin
                    if (ld_valid_i) ld_addr_d = ld_last_o ? '0 : ld_next[ADDR_W-1:0];
                end
                CONV: k_d = tap_last_o ? '0 : k_q + KLEN_W'(1);
                WR_OUT: begin
                    if (out_last_o) begin
                        o_d    = '0;
                        base_d = '0;
                        rd_d   = '0;
                    end else begin
                        o_d    = o_q + ADDR_W'(1);
                        base_d = base_q + ADDR_W'(stride_i);
                    end
                end
                RD_OUT: begin
                    if (rd_ready_i) rd_d = rd_last_o ? '0 : rd_q + ADDR_W'(1);
                end
                default: begin
                    ld_addr_d = '0;
                    k_d       = '0;
                    o_d       = '0;
                    base_d    = '0;
                    rd_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_addr_q <= '0;
            k_q       <= '0;
            o_q       <= '0;
            base_q    <= '0;
            rd_q      <= '0;
        end else begin
            ld_addr_q <= ld_addr_d;
            k_q       <= k_d;
            o_q       <= o_d;
            base_q    <= base_d;
            rd_q      <= rd_d;
        end
    end

    always_comb begin
        in_addr_o  = '0;
        kr_addr_o  = '0;
        out_addr_o = '0;
        case (state_i)
            LOAD_IN: in_addr_o = ld_addr_q;
            LOAD_KR: kr_addr_o = ld_addr_q[KLEN_W-1:0];
            CONV: begin
                in_addr_o = base_q + ADDR_W'(k_q);
                kr_addr_o = k_q;
            end
            WR_OUT:  out_addr_o = o_q;
            RD_OUT:  out_addr_o = rd_q;
            default: ;
        endcase
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Convolution run sequencer: config, beat loads, per-output MAC passes, readback.
// Define CONV_STRIDE_EN to add the cfg_stride input and an iterative M divide in CFG.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int KLEN_W = KLEN_W_DEF,
    parameter int BEAT   = BEAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              cfg_valid,
    input  logic [ADDR_W-1:0] cfg_in_len,
    input  logic [KLEN_W-1:0] cfg_kr_len,
`ifdef CONV_STRIDE_EN
    input  logic [3:0]        cfg_stride,
`endif
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic              in_en,
    output logic              in_we,
    output logic [ADDR_W-1:0] in_addr,
    output logic              kr_en,
    output logic              kr_we,
    output logic [KLEN_W-1:0] kr_addr,
    output logic              out_en,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic              mac_en,
    output logic              acc_clr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        dbg_state
);

    // Handshakes: a load beat moves on a cycle with ld_valid && ld_ready, an output word
    // on rd_valid && rd_ready; ld_ready/rd_valid depend on state only, never on the partner.
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   n_q, n_d, m_q, m_d;
    logic [KLEN_W-1:0]   k_q, k_d;
    logic                done_q, done_d, cfg_err_q, cfg_err_d;
    logic                cfg_bad;
    logic [STRIDE_W-1:0] stride_s;
    logic                ld_last, tap_last, out_last, rd_last;

`ifdef CONV_STRIDE_EN
    localparam int CNT_W = $clog2(ADDR_W + 1);
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
    logic [STRIDE_W:0]   div_rem_q, div_rem_d, div_try;
    logic [ADDR_W-1:0]   div_quo_q, div_quo_d;
    logic                div_bit;

    assign stride_s = stride_q;
    assign cfg_bad  = (cfg_in_len == '0) || (cfg_kr_len == '0) || (cfg_stride == '0) ||
                      (ADDR_W'(cfg_kr_len) > cfg_in_len);
    // Restoring divide of (N-K) by S, one quotient bit per cycle, MSB first.
    assign div_try  = {div_rem_q[STRIDE_W-1:0], div_quo_q[ADDR_W-1]};
    assign div_bit  = (div_try >= {1'b0, stride_q});
`else
    assign stride_s = STRIDE_W'(1);
    assign cfg_bad  = (cfg_in_len == '0) || (cfg_kr_len == '0) ||
                      (ADDR_W'(cfg_kr_len) > cfg_in_len);
`endif

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        m_d       = m_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
`ifdef CONV_STRIDE_EN
        stride_d  = stride_q;
        div_cnt_d = div_cnt_q;
        div_rem_d = div_rem_q;
        div_quo_d = div_quo_q;
`endif
        case (state_q)
            IDLE: if (start) state_d = CFG;
            CFG: begin
`ifdef CONV_STRIDE_EN
                if (div_cnt_q != '0) begin
                    div_rem_d = div_bit ? div_try - {1'b0, stride_q} : div_try;
                    div_quo_d = {div_quo_q[ADDR_W-2:0], div_bit};
                    div_cnt_d = div_cnt_q - CNT_W'(1);
                    if (div_cnt_q == CNT_W'(1)) begin
                        m_d     = {div_quo_q[ADDR_W-2:0], div_bit} + ADDR_W'(1);
                        state_d = LOAD_IN;
                    end
                end else if (cfg_valid) begin
                    n_d      = cfg_in_len;
                    k_d      = cfg_kr_len;
                    stride_d = cfg_stride;
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        div_quo_d = cfg_in_len - ADDR_W'(cfg_kr_len);
                        div_rem_d = '0;
                        div_cnt_d = CNT_W'(ADDR_W);
                    end
                end
`else
                if (cfg_valid) begin
                    n_d = cfg_in_len;
                    k_d = cfg_kr_len;
                    m_d = cfg_in_len - ADDR_W'(cfg_kr_len) + ADDR_W'(1);
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        state_d = LOAD_IN;
                    end
                end
`endif
            end
            LOAD_IN: if (ld_valid && ld_last) state_d = LOAD_KR;
            LOAD_KR: if (ld_valid && ld_last) state_d = CONV;
            CONV:    if (tap_last) state_d = WR_OUT;
            WR_OUT:  state_d = out_last ? RD_OUT : CONV;
            RD_OUT: begin
                if (rd_ready && rd_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            done_d    = 1'b0;
            cfg_err_d = 1'b0;
`ifdef CONV_STRIDE_EN
            div_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            n_q       <= '0;
            k_q       <= '0;
            m_q       <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
`ifdef CONV_STRIDE_EN
            stride_q  <= '0;
            div_cnt_q <= '0;
            div_rem_q <= '0;
            div_quo_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            m_q       <= m_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
`ifdef CONV_STRIDE_EN
            stride_q  <= stride_d;
            div_cnt_q <= div_cnt_d;
            div_rem_q <= div_rem_d;
            div_quo_q <= div_quo_d;
`endif
        end
    end

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .KLEN_W (KLEN_W),
        .BEAT   (BEAT)
    ) u_addr_gen (
        .clk_i      (clk),
        .rst_ni     (rst),
        .state_i    (state_q),
        .abort_i    (abort),
        .ld_valid_i (ld_valid),
        .rd_ready_i (rd_ready),
        .n_i        (n_q),
        .k_i        (k_q),
        .m_i        (m_q),
        .stride_i   (stride_s),
        .in_addr_o  (in_addr),
        .kr_addr_o  (kr_addr),
        .out_addr_o (out_addr),
        .ld_last_o  (ld_last),
        .tap_last_o (tap_last),
        .out_last_o (out_last),
        .rd_last_o  (rd_last)
    );

    always_comb begin
        ld_ready = 1'b0;
        rd_valid = 1'b0;
        in_en    = 1'b0;
        in_we    = 1'b0;
        kr_en    = 1'b0;
        kr_we    = 1'b0;
        out_en   = 1'b0;
        out_we   = 1'b0;
        mac_en   = 1'b0;
        acc_clr  = 1'b0;
        case (state_q)
            LOAD_IN: begin
                ld_ready = 1'b1;
                in_en    = 1'b1;
                in_we    = ld_valid;
            end
            LOAD_KR: begin
                ld_ready = 1'b1;
                kr_en    = 1'b1;
                kr_we    = ld_valid;
            end
            CONV: begin
                in_en  = 1'b1;
                kr_en  = 1'b1;
                mac_en = 1'b1;
            end
            WR_OUT: begin
                out_en  = 1'b1;
                out_we  = 1'b1;
                acc_clr = 1'b1;
            end
            RD_OUT: begin
                out_en   = 1'b1;
                rd_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

endmodule
